// File: rtl/nibble_seq_comparator.sv
// Wide unsigned magnitude compare using one time-shared 4-bit cascadable slice, one nibble per clock.
// Optional macro NIBBLE_SEQ_CMP_EARLY_EXIT_EN: MSB-first scan that stops at the first unequal nibble.
module nibble_seq_comparator #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_gt,
  output logic             res_eq,
  output logic             res_lt,
  output logic             busy
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b;
  logic             cg, ce, cl;
  logic [IW-1:0]    idx;
  logic [3:0]       an, bn;
  logic             nib_eq, gt_n, eq_n, lt_n, last;

  assign an     = op_a[idx*4 +: 4];
  assign bn     = op_b[idx*4 +: 4];
  assign nib_eq = (an == bn);

  // Same slice in both modes: MSB-first keeps ce=1 until the first unequal nibble, where it exits.
  assign gt_n = (an > bn) | (nib_eq & ~ce & cg);
  assign eq_n = nib_eq & ce;
  assign lt_n = (an < bn) | (nib_eq & ~ce & cl);

`ifdef NIBBLE_SEQ_CMP_EARLY_EXIT_EN
  localparam logic [IW-1:0] IDX_START = IW'(NIB - 1);
  assign last = ~nib_eq | (idx == '0);
`else
  localparam logic [IW-1:0] IDX_START = '0;
  assign last = (idx == IW'(NIB - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      cg     <= 1'b0;
      ce     <= 1'b1;
      cl     <= 1'b0;
      idx    <= '0;
      res_gt <= 1'b0;
      res_eq <= 1'b0;
      res_lt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_a <= a;
            op_b <= b;
            cg   <= 1'b0;
            ce   <= 1'b1;
            cl   <= 1'b0;
            idx  <= IDX_START;
          end
        end
        RUN: begin
          cg <= gt_n;
          ce <= eq_n;
          cl <= lt_n;
          if (last) begin
            res_gt <= gt_n;
            res_eq <= eq_n;
            res_lt <= lt_n;
          end else begin
`ifdef NIBBLE_SEQ_CMP_EARLY_EXIT_EN
            idx <= idx - IW'(1);
`else
            idx <= idx + IW'(1);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/nibble_seq_comparator.md
Name: nibble_seq_comparator

Overview:
Compares two WIDTH-bit unsigned operands with a single time-shared 4-bit cascadable magnitude-comparator slice. The slice is stepped one nibble per clock, and the slice's cascade outputs are registered and fed back as its cascade inputs. The block is used where the arcade cores need wide compares (sprite X/Y match, scroll limits) without instantiating WIDTH/4 comparator packages. It has a valid/ready request port and a valid/ready result port.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4; NIB = WIDTH/4.

Ports:
clk        input   1      system clock, all state on rising edge
rst_n      input   1      asynchronous active-low reset
req_valid  input   1      request strobe; a, b valid
req_ready  output  1      block can accept a request
a          input   WIDTH  operand A, unsigned
b          input   WIDTH  operand B, unsigned
res_valid  output  1      result flags valid
res_ready  input   1      consumer accepts result
res_gt     output  1      A > B
res_eq     output  1      A == B
res_lt     output  1      A < B
busy       output  1      high in RUN or DONE

Behaviour:
- One clock domain. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state=IDLE, req_ready=1, res_valid=0, res_gt=0, res_eq=0, res_lt=0, busy=0.
  - Internal cascade regs cg=0, ce=1, cl=0. Nibble index idx=0.
- Slice equations, applied to nibbles An, Bn with cascade regs:
  - gt' = (An>Bn) | (An==Bn & !ce & cg)
  - eq' = (An==Bn) & ce
  - lt' = (An<Bn) | (An==Bn & !ce & cl)
- State IDLE:
  - req_ready=1.
  - On req_valid, capture a and b into operand regs, load cg=0, ce=1, cl=0, idx=0, go to RUN.
- State RUN:
  - req_ready=0, busy=1.
  - Each cycle, evaluate the slice on nibble idx (nibble 0 = bits 3:0), register gt'/eq'/lt' into cg/ce/cl, then idx++.
  - When the evaluated nibble is NIB-1, load the res_* regs from gt'/eq'/lt' and go to DONE.
- State DONE:
  - res_valid=1, busy=1.
  - res_* are held stable while res_ready=0.
  - On res_ready, go to IDLE. res_valid falls the next cycle; res_* keep their last values and are qualified only by res_valid.
- Latency: the request is accepted at edge E0, and res_valid is high after edge E_NIB (4 clocks for WIDTH=16).
- Throughput: a new request is accepted at the earliest in the cycle after the result handshake. The minimum request-to-request spacing is NIB+2 clocks.
- Exactly one of res_gt/res_eq/res_lt is 1 whenever res_valid=1.
- Input changes during RUN/DONE are ignored; only the captured operands are used.
- req_valid while req_ready=0 is ignored (not queued).
- idx wraps only via the reload in IDLE; no overflow path exists.
- rst_n asserted in any state: immediate return to reset values. The in-flight compare is discarded and no res_valid is produced.
- WIDTH=4: RUN lasts exactly one cycle.

Optional Feature:
Macro NIBBLE_SEQ_CMP_EARLY_EXIT_EN.
- Defined:
  - RUN scans MSB-first, starting at nibble NIB-1 and decrementing.
  - On the first nibble with An>Bn, load res_gt=1 and go to DONE immediately. On An<Bn, load res_lt=1 likewise.
  - If all nibbles are equal, load res_eq=1 after nibble 0.
  - Latency is 1..NIB clocks, data-dependent. Flags are identical to non-EE mode.
- Undefined:
  - LSB-first cascade scan as above, fixed NIB-clock latency.
  - No early-exit logic is synthesised.

Test Plan:
1. Reset and idle:
   - Stimulus: hold rst_n=0, then release.
   - Required: all outputs at reset values, req_ready=1, busy=0; no res_valid for 10 idle clocks.
2. Equal operands (WIDTH=16):
   - Stimulus: a=16'h1234, b=16'h1234, res_ready=1.
   - Required: res_eq=1, gt=lt=0. res_valid rises exactly 4 clocks after acceptance. EE build: also 4 clocks.
3. Greater (WIDTH=16):
   - Stimulus: a=16'h8000, b=16'h7FFF.
   - Required: res_gt=1. Latency 4 clocks; EE build 1 clock.
4. Less (WIDTH=16):
   - Stimulus: a=16'h00FF, b=16'h0100.
   - Required: res_lt=1. Latency 4 clocks; EE build 2 clocks.
   - Stimulus: a=16'h0001, b=16'h0002.
   - Required: res_lt=1. EE build 4 clocks.
5. Backpressure:
   - Stimulus: hold res_ready=0 for 6 clocks after res_valid; pulse req_valid with a=16'hFFFF meanwhile.
   - Required: res_* stable, req_ready=0, the extra request is ignored. After res_ready=1, one more clock passes before req_ready=1.
6. Reset mid-operation:
   - Stimulus: assert rst_n=0 two clocks into RUN.
   - Required: state returns to IDLE immediately, res_valid never asserts. The next request, a=16'h0005, b=16'h0003, gives res_gt=1 normally.
